// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - two-stage decode/issue and retire controller driving a combinational ALU
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [1:0]  alu_mode,
  output logic [3:0]  alu_opcode,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_result,
  input  logic [1:0]  alu_overflow,
  input  logic        alu_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_we,
  output logic        out_zero,
  output logic        out_trap,
  output logic        out_illegal
);

  localparam logic [1:0] MODE_U = 2'b00;
  localparam logic [1:0] MODE_S = 2'b01;

  // ID/EX stage
  logic        s1_valid_q, s1_valid_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [1:0]  mode_q, mode_d;
  logic [3:0]  op_q, op_d;
  logic [4:0]  shamt_q, shamt_d, rd_q, rd_d;
  logic        we_q, we_d, ill_q, ill_d;

  // EX/WB stage
  logic        out_valid_q, out_valid_d;
  logic [31:0] res_q, res_d;
  logic [4:0]  wrd_q, wrd_d;
  logic        wwe_q, wwe_d, zero_q, zero_d, trap_q, trap_d, will_q, will_d;

  // decode results
  logic [31:0] dec_a, dec_b, imm_s, imm_z;
  logic [1:0]  dec_mode;
  logic [3:0]  dec_op;
  logic [4:0]  dec_shamt, dec_rd;
  logic        dec_we, dec_ill;

  logic s2_adv, s1_adv, accept, trap_now;
  logic unused_ok;

  // only bit 0 of the overflow bus carries meaning; rs index is not needed
  assign unused_ok = ^{alu_overflow[1], instr[25:21]};

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_adv;
  assign in_ready = !s1_valid_q || s1_adv;
  assign accept   = in_valid && in_ready && !flush;
  assign imm_s    = {{16{instr[15]}}, instr[15:0]};
  assign imm_z    = {16'h0000, instr[15:0]};
  assign trap_now = alu_overflow[0] && (mode_q == MODE_S) && (op_q == 4'b0000 || op_q == 4'b0001);

  // instruction decode into ALU controls, operands and writeback qualifiers
  always_comb begin
    dec_a     = rs_val;
    dec_b     = rt_val;
    dec_mode  = MODE_U;
    dec_op    = 4'b0000;
    dec_shamt = 5'd0;
    dec_rd    = instr[20:16];
    dec_we    = 1'b1;
    dec_ill   = 1'b0;
    case (instr[31:26])
      6'b000000: begin
        dec_rd = instr[15:11];
        case (instr[5:0])
          6'b100000: begin dec_op = 4'b0000; dec_mode = MODE_S; end
          6'b100001: dec_op = 4'b0000;
          6'b100010: begin dec_op = 4'b0001; dec_mode = MODE_S; end
          6'b100011: dec_op = 4'b0001;
          6'b100100: dec_op = 4'b0010;
          6'b100101: dec_op = 4'b0011;
          6'b000000: begin dec_op = 4'b0100; dec_shamt = instr[10:6]; end
          6'b000010: begin dec_op = 4'b0101; dec_shamt = instr[10:6]; end
          6'b000011: begin dec_op = 4'b0110; dec_shamt = instr[10:6]; end
          6'b101010: begin dec_op = 4'b1000; dec_mode = MODE_S; end
          6'b101011: dec_op = 4'b1000;
          default:   dec_ill = 1'b1;
        endcase
      end
      6'b001000: begin dec_op = 4'b0000; dec_mode = MODE_S; dec_b = imm_s; end
      6'b001001: begin dec_op = 4'b0000; dec_b = imm_s; end
      6'b001100: begin dec_op = 4'b0010; dec_b = imm_z; end
      6'b001101: begin dec_op = 4'b0011; dec_b = imm_z; end
      6'b001010: begin dec_op = 4'b1000; dec_mode = MODE_S; dec_b = imm_s; end
      6'b001011: begin dec_op = 4'b1000; dec_b = imm_s; end
      6'b000100: begin dec_op = 4'b0001; dec_rd = 5'd0; dec_we = 1'b0; end
      default:   dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      dec_a     = 32'd0;
      dec_b     = 32'd0;
      dec_mode  = MODE_U;
      dec_op    = 4'b0000;
      dec_shamt = 5'd0;
      dec_rd    = 5'd0;
      dec_we    = 1'b0;
    end
    if (dec_rd == 5'd0) dec_we = 1'b0;
  end

  // ID/EX next state: flush kills, otherwise load on accept or drain on advance
  always_comb begin
    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    mode_d     = mode_q;
    op_d       = op_q;
    shamt_d    = shamt_q;
    rd_d       = rd_q;
    we_d       = we_q;
    ill_d      = ill_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (accept) begin
      s1_valid_d = 1'b1;
      a_d        = dec_a;
      b_d        = dec_b;
      mode_d     = dec_mode;
      op_d       = dec_op;
      shamt_d    = dec_shamt;
      rd_d       = dec_rd;
      we_d       = dec_we;
      ill_d      = dec_ill;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // EX/WB next state: capture ALU outputs when s1 advances and was not flushed
  always_comb begin
    out_valid_d = out_valid_q;
    res_d       = res_q;
    wrd_d       = wrd_q;
    wwe_d       = wwe_q;
    zero_d      = zero_q;
    trap_d      = trap_q;
    will_d      = will_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q && !flush;
      if (s1_valid_q && !flush) begin
        res_d  = alu_result;
        wrd_d  = rd_q;
        zero_d = alu_zero;
        trap_d = trap_now;
        wwe_d  = we_q && !trap_now;
        will_d = ill_q;
      end
    end
  end

  // pipeline registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      mode_q      <= '0;
      op_q        <= '0;
      shamt_q     <= '0;
      rd_q        <= '0;
      we_q        <= 1'b0;
      ill_q       <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      wrd_q       <= '0;
      wwe_q       <= 1'b0;
      zero_q      <= 1'b0;
      trap_q      <= 1'b0;
      will_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mode_q      <= mode_d;
      op_q        <= op_d;
      shamt_q     <= shamt_d;
      rd_q        <= rd_d;
      we_q        <= we_d;
      ill_q       <= ill_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      wrd_q       <= wrd_d;
      wwe_q       <= wwe_d;
      zero_q      <= zero_d;
      trap_q      <= trap_d;
      will_q      <= will_d;
    end
  end

  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_mode    = mode_q;
  assign alu_opcode  = op_q;
  assign alu_shamt   = shamt_q;
  assign out_valid   = out_valid_q;
  assign out_result  = res_q;
  assign out_rd      = wrd_q;
  assign out_we      = wwe_q;
  assign out_zero    = zero_q;
  assign out_trap    = trap_q;
  assign out_illegal = will_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - scoreboard bench for alu_issue_ctrl with an attached ALU model
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, flush, out_ready;
  logic [31:0] instr, rs_val, rt_val;
  logic        in_ready, out_valid, out_we, out_zero, out_trap, out_illegal;
  logic [31:0] alu_a, alu_b, alu_result, out_result;
  logic [1:0]  alu_mode, alu_overflow;
  logic [3:0]  alu_opcode;
  logic [4:0]  alu_shamt, out_rd;
  logic        alu_zero;

  int passed = 0;
  int total = 0;
  int retired = 0;
  logic [40:0] exp_q[$];

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
    .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_opcode(alu_opcode),
    .alu_shamt(alu_shamt), .alu_result(alu_result), .alu_overflow(alu_overflow),
    .alu_zero(alu_zero), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_we(out_we), .out_zero(out_zero),
    .out_trap(out_trap), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  // combinational ALU; unsigned modes report carry/borrow on bit 0, bit 1 is noise
  logic [32:0] t_w;
  always_comb begin
    alu_result   = 32'd0;
    alu_overflow = 2'b10;
    t_w          = 33'd0;
    case (alu_opcode)
      4'b0000: begin
        t_w = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = t_w[31:0];
        alu_overflow[0] = (alu_mode == 2'b01) ? ((alu_a[31] == alu_b[31]) && (t_w[31] != alu_a[31])) : t_w[32];
      end
      4'b0001: begin
        t_w = {1'b0, alu_a} - {1'b0, alu_b};
        alu_result = t_w[31:0];
        alu_overflow[0] = (alu_mode == 2'b01) ? ((alu_a[31] != alu_b[31]) && (t_w[31] != alu_a[31])) : t_w[32];
      end
      4'b0010: alu_result = alu_a & alu_b;
      4'b0011: alu_result = alu_a | alu_b;
      4'b0100: alu_result = alu_b << alu_shamt;
      4'b0101: alu_result = alu_b >> alu_shamt;
      4'b0110: alu_result = $signed(alu_b) >>> alu_shamt;
      4'b1000: begin
        t_w = {1'b0, alu_a} - {1'b0, alu_b};
        alu_result = (alu_mode == 2'b01) ? {31'd0, $signed(alu_a) < $signed(alu_b)} : {31'd0, alu_a < alu_b};
        alu_overflow[0] = (alu_a[31] != alu_b[31]) && (t_w[31] != alu_a[31]);
      end
      default: alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) $display("FAIL %s: got %h expected %h", name, act, req);
    else passed++;
  endtask

  // architectural result of one instruction: {result, rd, we, zero, trap, illegal}
  function automatic logic [40:0] model(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r, si, zi;
    logic [4:0]  rd;
    logic        trap, ill, wr;
    longint      s;
    r = 0; trap = 0; ill = 0; wr = 1;
    si = {{16{i[15]}}, i[15:0]};
    zi = {16'h0, i[15:0]};
    rd = i[20:16];
    case (i[31:26])
      6'd0: begin
        rd = i[15:11];
        case (i[5:0])
          6'h20: begin r = a + b; s = longint'($signed(a)) + longint'($signed(b)); trap = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
          6'h21: r = a + b;
          6'h22: begin r = a - b; s = longint'($signed(a)) - longint'($signed(b)); trap = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
          6'h23: r = a - b;
          6'h24: r = a & b;
          6'h25: r = a | b;
          6'h00: r = b << i[10:6];
          6'h02: r = b >> i[10:6];
          6'h03: r = $signed(b) >>> i[10:6];
          6'h2A: r = ($signed(a) < $signed(b)) ? 1 : 0;
          6'h2B: r = (a < b) ? 1 : 0;
          default: ill = 1;
        endcase
      end
      6'h08: begin r = a + si; s = longint'($signed(a)) + longint'($signed(si)); trap = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      6'h09: r = a + si;
      6'h0C: r = a & zi;
      6'h0D: r = a | zi;
      6'h0A: r = ($signed(a) < $signed(si)) ? 1 : 0;
      6'h0B: r = (a < si) ? 1 : 0;
      6'h04: begin r = a - b; rd = 0; wr = 0; end
      default: ill = 1;
    endcase
    if (ill) begin r = 0; rd = 0; wr = 0; end
    wr = wr && (rd != 0) && !trap;
    return {r, rd, wr, (r == 0), trap, ill};
  endfunction

  // scoreboard: retire, then flush kill, then push the op accepted at the coming edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_retire", {63'd0, out_valid}, 64'd0);
        else chk("retire", {23'd0, out_result, out_rd, out_we, out_zero, out_trap, out_illegal}, {23'd0, exp_q.pop_front()});
        retired++;
      end
      if (flush) begin
        while (exp_q.size() > ((out_valid && !out_ready) ? 1 : 0)) void'(exp_q.pop_back());
      end
      if (in_valid && in_ready && !flush) exp_q.push_back(model(instr, rs_val, rt_val));
    end
  end

  function automatic logic [31:0] rt(input logic [5:0] fn, input logic [4:0] rd, input logic [4:0] sh);
    return {6'd0, 5'd1, 5'd2, rd, sh, fn};
  endfunction

  function automatic logic [31:0] it(input logic [5:0] op, input logic [4:0] rd, input logic [15:0] imm);
    return {op, 5'd1, rd, imm};
  endfunction

  task automatic send(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    logic acc;
    in_valid = 1; instr = i; rs_val = a; rt_val = b;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk); acc = in_ready && !flush;
      @(posedge clk); #1;
      if (acc) begin in_valid = 0; return; end
    end
    chk("send_timeout", {63'd0, acc}, 64'd1);
    in_valid = 0;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      4: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [5:0] fns[11];
    logic [5:0] ops[6];
    logic [4:0] rd;
    fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h00, 6'h02, 6'h03, 6'h2A, 6'h2B};
    ops = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0A, 6'h0B};
    rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    case ($urandom_range(0, 3))
      0, 1: return rt(fns[$urandom_range(0, 10)], rd, 5'($urandom));
      2: return it(ops[$urandom_range(0, 5)], rd, 16'($urandom));
      default: case ($urandom_range(0, 2))
        0: return {6'h04, 26'($urandom)};
        1: return {6'h3F, 26'($urandom)};
        default: return rt(6'h3F, rd, 5'd0);
      endcase
    endcase
  endfunction

  logic [31:0] bp_i[4], bp_a[4], bp_b[4];
  logic [40:0] snap;
  int nacc, idx, r0;
  logic acc;

  initial begin
    rst_n = 0; in_valid = 0; flush = 0; out_ready = 1; instr = 0; rs_val = 0; rt_val = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_alu", {alu_a, alu_b}, 64'd0);
    chk("rst_alu_ctl", {53'd0, alu_mode, alu_opcode, alu_shamt}, 64'd0);
    rst_n = 1;
    @(posedge clk); #1;

    // add overflow, also measuring latency through an empty pipe
    send(rt(6'h20, 5'd3, 5'd0), 32'h7FFFFFFF, 32'd1);
    chk("add_alu_mode", {62'd0, alu_mode}, 64'd1);
    chk("lat_not_early", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    chk("lat_present", {63'd0, out_valid}, 64'd1);
    send(rt(6'h21, 5'd4, 5'd0), 32'hFFFFFFFF, 32'd1);
    send(rt(6'h03, 5'd5, 5'd4), 32'd0, 32'h80000000);
    chk("sra_shamt", {59'd0, alu_shamt}, 64'd4);
    send(it(6'h0A, 5'd6, 16'h0000), 32'hFFFFFFFF, 32'd0);
    send({6'h04, 5'd1, 5'd2, 16'h0003}, 32'h1234, 32'h1234);
    send(32'hFC000000, 32'h55, 32'h66);
    repeat (4) @(posedge clk);
    #1;

    // backpressure: only two ops fit while the consumer stalls
    for (int k = 0; k < 4; k++) begin
      bp_i[k] = rt(6'h21, 5'(k + 8), 5'd0); bp_a[k] = 32'(k * 100); bp_b[k] = 32'(k);
    end
    out_ready = 0; nacc = 0; idx = 0;
    in_valid = 1; instr = bp_i[0]; rs_val = bp_a[0]; rt_val = bp_b[0];
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      acc = in_ready;
      if (c == 2) snap = {9'd0, alu_a, alu_opcode, alu_shamt};
      if (c == 3) begin
        chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        chk("bp_alu_stable", {23'd0, 9'd0, alu_a, alu_opcode, alu_shamt}, {23'd0, snap});
      end
      @(posedge clk); #1;
      if (acc) begin nacc++; idx++; instr = bp_i[idx]; rs_val = bp_a[idx]; rt_val = bp_b[idx]; end
    end
    chk("bp_accepts", 64'(nacc), 64'd2);
    in_valid = 0; out_ready = 1;
    send(bp_i[2], bp_a[2], bp_b[2]);
    send(bp_i[3], bp_a[3], bp_b[3]);
    repeat (4) @(posedge clk);
    #1;

    // flush on an accept cycle while s1 advances: only the s2 op retires
    r0 = retired;
    out_ready = 0;
    send(rt(6'h24, 5'd10, 5'd0), 32'hF0F0, 32'hFF00);
    send(rt(6'h25, 5'd11, 5'd0), 32'h1, 32'h2);
    in_valid = 1; instr = rt(6'h21, 5'd12, 5'd0); rs_val = 5; rt_val = 6;
    flush = 1; out_ready = 1;
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    chk("flush_kills_s1", {63'd0, out_valid}, 64'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("flush_retired", 64'(retired - r0), 64'd1);

    // asynchronous reset in the middle of a stream
    out_ready = 0;
    send(rt(6'h21, 5'd13, 5'd0), 32'd7, 32'd8);
    send(rt(6'h21, 5'd14, 5'd0), 32'd9, 32'd10);
    #2 rst_n = 0;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1; out_ready = 1;
    @(posedge clk); #1;

    // randomized traffic with random backpressure and occasional flush
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      instr     = rnd_instr();
      rs_val    = rnd_val();
      rt_val    = rnd_val();
      @(posedge clk); #1;
    end
    in_valid = 0; flush = 0; out_ready = 1;
    repeat (6) @(posedge clk);
    #1;
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_out_valid", {63'd0, out_valid}, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
